// File: rtl/bank_arbiter.sv
// bank_arbiter: round-robin grant of one banked-memory port with per-bank busy windows
module bank_arbiter #(
  parameter int NREQ = 4,
  parameter int NBANK = 32,
  parameter int BUSY = 2,
  localparam int A = $clog2(NBANK),
  localparam int IW = $clog2(NREQ),
  localparam int CW = BUSY > 1 ? $clog2(BUSY) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*A-1:0] req_addr,
  output logic [NREQ-1:0]   req_ready,
  output logic [NBANK-1:0]  csel,
  output logic              gnt_valid,
  output logic [IW-1:0]     gnt_id,
  output logic [NBANK-1:0]  bank_busy
);
  logic [A-1:0] addr [NREQ];
  logic [CW-1:0] cnt [NBANK];
  logic [NREQ-1:0] elig;
  logic [IW-1:0] ptr;
  logic [IW-1:0] w;
  logic [A-1:0] waddr;
  logic found;
  int j;
  genvar g;
  for (g = 0; g < NREQ; g++) begin : g_req
    assign addr[g] = req_addr[g*A +: A];
    assign elig[g] = req_valid[g] && 32'(addr[g]) < NBANK && cnt[addr[g]] == '0;
  end
  for (g = 0; g < NBANK; g++) begin : g_bank
    assign bank_busy[g] = cnt[g] != '0;
  end
  always_comb begin
    found = 1'b0;
    w = '0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      j = j >= NREQ ? j - NREQ : j;
      if (!found && elig[IW'(j)]) begin
        found = 1'b1;
        w = IW'(j);
      end
    end
  end
  assign waddr = addr[w];
  assign req_ready = found ? NREQ'(1) << w : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      csel <= '0;
      gnt_valid <= 1'b0;
      gnt_id <= '0;
      for (int b = 0; b < NBANK; b++) cnt[b] <= '0;
    end else begin
      gnt_valid <= found;
      csel <= found ? NBANK'(1) << waddr : '0;
      if (found) begin
        gnt_id <= w;
        ptr <= 32'(w) == NREQ - 1 ? '0 : w + 1'b1;
      end
      // a granted bank is always idle, so load and decrement never collide
      for (int b = 0; b < NBANK; b++)
        cnt[b] <= found && 32'(waddr) == b ? CW'(BUSY - 1) : cnt[b] - CW'(cnt[b] != '0);
    end
  end
endmodule

// File: tb/tb_bank_arbiter.sv
// tb_bank_arbiter: scoreboard bench over three parameter sets sharing one stimulus
module tb_bank_arbiter;
  typedef struct {
    logic [31:0] cs;
    logic        gv;
    logic [1:0]  gid;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] valid;
  logic [19:0] raddr;
  logic [3:0] rdy0, rdy1, rdy2;
  logic [31:0] cs0, cs2, bb0, bb2;
  logic [23:0] cs1, bb1;
  logic gv0, gv1, gv2;
  logic [1:0] gid0, gid1, gid2;
  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int m_ptr [3];
  int m_gid [3];
  int m_cnt [3][32];
  int nb [3] = '{32, 24, 32};
  int bz [3] = '{2, 2, 4};
  always #5 clk = ~clk;
  bank_arbiter #(.NREQ(4), .NBANK(32), .BUSY(2)) u0 (.clk(clk), .rst(rst), .req_valid(valid),
    .req_addr(raddr), .req_ready(rdy0), .csel(cs0), .gnt_valid(gv0), .gnt_id(gid0), .bank_busy(bb0));
  bank_arbiter #(.NREQ(4), .NBANK(24), .BUSY(2)) u1 (.clk(clk), .rst(rst), .req_valid(valid),
    .req_addr(raddr), .req_ready(rdy1), .csel(cs1), .gnt_valid(gv1), .gnt_id(gid1), .bank_busy(bb1));
  bank_arbiter #(.NREQ(4), .NBANK(32), .BUSY(4)) u2 (.clk(clk), .rst(rst), .req_valid(valid),
    .req_addr(raddr), .req_ready(rdy2), .csel(cs2), .gnt_valid(gv2), .gnt_id(gid2), .bank_busy(bb2));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", tag, got, exp);
  endtask
  task automatic cycle_check();
    exp_t e, n;
    logic [31:0] mb;
    int w, a, i, ai;
    for (int k = 0; k < 3; k++) begin
      e = sb.pop_front();
      chk($sformatf("csel[%0d]", k), k == 0 ? cs0 : k == 1 ? 32'(cs1) : cs2, e.cs);
      chk($sformatf("gnt_valid[%0d]", k), 32'(k == 0 ? gv0 : k == 1 ? gv1 : gv2), 32'(e.gv));
      chk($sformatf("gnt_id[%0d]", k), 32'(k == 0 ? gid0 : k == 1 ? gid1 : gid2), 32'(e.gid));
      mb = '0;
      for (int b = 0; b < nb[k]; b++) mb[b] = m_cnt[k][b] != 0;
      chk($sformatf("bank_busy[%0d]", k), k == 0 ? bb0 : k == 1 ? 32'(bb1) : bb2, mb);
      if (rst) begin
        m_ptr[k] = 0;
        m_gid[k] = 0;
        for (int b = 0; b < 32; b++) m_cnt[k][b] = 0;
        n.cs = '0;
        n.gv = 1'b0;
        n.gid = '0;
      end else begin
        w = -1;
        a = 0;
        for (int s = 0; s < 4; s++) begin
          i = (m_ptr[k] + s) % 4;
          ai = int'(raddr[i*5 +: 5]);
          if (w < 0 && valid[i] && ai < nb[k] && m_cnt[k][ai] == 0) begin
            w = i;
            a = ai;
          end
        end
        chk($sformatf("req_ready[%0d]", k), 32'(k == 0 ? rdy0 : k == 1 ? rdy1 : rdy2),
            w >= 0 ? 32'(1) << w : 32'(0));
        for (int b = 0; b < 32; b++) if (m_cnt[k][b] > 0) m_cnt[k][b]--;
        if (w >= 0) begin
          m_cnt[k][a] = bz[k] - 1;
          m_ptr[k] = (w + 1) % 4;
          m_gid[k] = w;
        end
        n.cs = w >= 0 ? 32'(1) << a : 32'(0);
        n.gv = w >= 0;
        n.gid = 2'(m_gid[k]);
      end
      sb.push_back(n);
    end
  endtask
  task automatic step(int cycles);
    repeat (cycles) begin
      @(negedge clk);
      cycle_check();
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drive(logic [3:0] v, int a0, int a1, int a2, int a3);
    valid = v;
    raddr = {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endtask
  initial begin
    exp_t r;
    r.cs = '0;
    r.gv = 1'b0;
    r.gid = '0;
    repeat (3) sb.push_back(r);
    for (int k = 0; k < 3; k++) begin
      m_ptr[k] = 0;
      m_gid[k] = 0;
      for (int b = 0; b < 32; b++) m_cnt[k][b] = 0;
    end
    rst = 1'b1;
    drive(4'b0000, 0, 0, 0, 0);
    step(2);
    rst = 1'b0;
    step(3);
    drive(4'b0010, 0, 15, 0, 0);
    step(1);
    drive(4'b0000, 0, 15, 0, 0);
    step(3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    drive(4'b1111, 0, 1, 2, 3);
    step(9);
    drive(4'b0000, 0, 0, 0, 0);
    step(4);
    drive(4'b0101, 5, 0, 5, 0);
    step(6);
    drive(4'b0000, 0, 0, 0, 0);
    step(4);
    drive(4'b0011, 30, 23, 0, 0);
    step(4);
    drive(4'b0000, 0, 0, 0, 0);
    step(4);
    drive(4'b0001, 7, 0, 0, 0);
    step(1);
    drive(4'b0000, 0, 0, 0, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    drive(4'b0001, 7, 0, 0, 0);
    step(2);
    drive(4'b1111, 31, 31, 23, 24);
    step(8);
    for (int c = 0; c < 300; c++) begin
      rst = $urandom_range(0, 40) == 0;
      drive(4'($urandom), $urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(20, 31),
            $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31));
      step(1);
    end
    rst = 1'b0;
    drive(4'b0000, 0, 0, 0, 0);
    step(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
